// File: rtl/bus_int_ack.sv
// Interrupt acknowledge sequencer: grants the winning level at an instruction boundary,
// captures the device vector and hands a trap request to the CPU. Optional: INT_TIMEOUT_EN.
module bus_int_ack #(
    parameter int TIMEOUT = 16,
    parameter int TCW     = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       result,
    input  logic [7:0] winner,
    input  logic       cpu_int_ok,
    input  logic       int_ack,
    input  logic [8:0] int_vector,
    input  logic       trap_ack,
    output logic [7:0] int_grant,
    output logic       trap_req,
    output logic [8:0] trap_vector,
    output logic [2:0] trap_ipl,
    output logic       busy,
    output logic       timeout_err
);

    typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, PRESENT = 2'd2} state_t;

    state_t     state_r, state_s;
    logic [7:0] grant_r, grant_s;
    logic       req_r, req_s;
    logic [8:0] vec_r, vec_s;
    logic [2:0] ipl_r, ipl_s;
    logic       busy_r, busy_s;
    logic       terr_r, terr_s;
    logic       start_s;
    logic       tmo_s;
    logic       unused_vec_s;

    // Binary index of the highest set bit of the one-hot winner.
    function automatic logic [2:0] enc_level(input logic [7:0] w);
        logic [2:0] lvl;
        lvl = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (w[i]) begin
                lvl = 3'(i);
            end else begin
                lvl = lvl;
            end
        end
        return lvl;
    endfunction

    assign unused_vec_s = ^int_vector[1:0];

    // Grant qualification sampled only in IDLE.
    always_comb begin
        start_s = result && cpu_int_ok && (winner != 8'h00);
    end

`ifdef INT_TIMEOUT_EN
    logic [TCW-1:0] cnt_r, cnt_s;

    // Release fires on the GRANT cycle where the counter would reach TIMEOUT; an ack wins.
    always_comb begin
        tmo_s = (state_r == GRANT) && !int_ack && (cnt_r == TCW'(TIMEOUT - 1));
    end

    // Counter next value: count unanswered GRANT cycles, clear otherwise.
    always_comb begin
        if ((state_r == GRANT) && !int_ack && !tmo_s) begin
            cnt_s = cnt_r + TCW'(1);
        end else begin
            cnt_s = {TCW{1'b0}};
        end
    end

    // Timeout counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= {TCW{1'b0}};
        end else begin
            cnt_r <= cnt_s;
        end
    end
`else
    logic [31:0] unused_cfg_s;
    assign unused_cfg_s = 32'(TIMEOUT) ^ 32'(TCW);

    // Without the timeout feature a grant is held until the device answers.
    always_comb begin
        tmo_s = 1'b0;
    end
`endif

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            grant_r <= 8'h00;
            req_r   <= 1'b0;
            vec_r   <= 9'd0;
            ipl_r   <= 3'd0;
            busy_r  <= 1'b0;
            terr_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            grant_r <= grant_s;
            req_r   <= req_s;
            vec_r   <= vec_s;
            ipl_r   <= ipl_s;
            busy_r  <= busy_s;
            terr_r  <= terr_s;
        end
    end

    // Next-state logic; PRESENT always returns through IDLE.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:    if (start_s)  state_s = GRANT;   else state_s = IDLE;
            GRANT:   if (int_ack)  state_s = PRESENT;
                     else if (tmo_s) state_s = IDLE;
                     else state_s = GRANT;
            PRESENT: if (trap_ack) state_s = IDLE;    else state_s = PRESENT;
            default: state_s = IDLE;
        endcase
    end

    // Next values of the registered outputs.
    always_comb begin
        grant_s = grant_r;
        req_s   = req_r;
        vec_s   = vec_r;
        ipl_s   = ipl_r;
        terr_s  = 1'b0;
        busy_s  = (state_s != IDLE);
        case (state_r)
            IDLE: begin
                if (start_s) begin
                    grant_s = winner;
                    ipl_s   = enc_level(winner);
                end else begin
                    grant_s = grant_r;
                end
            end
            GRANT: begin
                if (int_ack) begin
                    vec_s   = {int_vector[8:2], 2'b00};
                    grant_s = 8'h00;
                    req_s   = 1'b1;
                end else if (tmo_s) begin
                    grant_s = 8'h00;
                    terr_s  = 1'b1;
                end else begin
                    grant_s = grant_r;
                end
            end
            PRESENT: begin
                if (trap_ack) begin
                    req_s = 1'b0;
                end else begin
                    req_s = 1'b1;
                end
            end
            default: begin
                grant_s = 8'h00;
                req_s   = 1'b0;
                vec_s   = 9'd0;
                ipl_s   = 3'd0;
            end
        endcase
    end

    assign int_grant   = grant_r;
    assign trap_req    = req_r;
    assign trap_vector = vec_r;
    assign trap_ipl    = ipl_r;
    assign busy        = busy_r;
    assign timeout_err = terr_r;

endmodule

// File: tb/tb_bus_int_ack.sv
// Directed bench for bus_int_ack; timeout scenarios follow INT_TIMEOUT_EN.
module tb_bus_int_ack;

    logic       clk = 1'b0;
    logic       reset;
    logic       result;
    logic [7:0] winner;
    logic       cpu_int_ok;
    logic       int_ack;
    logic [8:0] int_vector;
    logic       trap_ack;
    logic [7:0] int_grant;
    logic       trap_req;
    logic [8:0] trap_vector;
    logic [2:0] trap_ipl;
    logic       busy;
    logic       timeout_err;

    int n_vec = 0;
    int n_bad = 0;

    bus_int_ack #(.TIMEOUT(16), .TCW(5)) dut (
        .clk(clk), .reset(reset), .result(result), .winner(winner),
        .cpu_int_ok(cpu_int_ok), .int_ack(int_ack), .int_vector(int_vector),
        .trap_ack(trap_ack), .int_grant(int_grant), .trap_req(trap_req),
        .trap_vector(trap_vector), .trap_ipl(trap_ipl), .busy(busy),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        result = 1'b0; winner = 8'h00; cpu_int_ok = 1'b0;
        int_ack = 1'b0; int_vector = 9'd0; trap_ack = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        #12;
        n_vec++; if (int_grant !== 8'h00) begin n_bad++; $display("FAIL rst_grant: got %h want 00", int_grant); end
        n_vec++; if (trap_req !== 1'b0) begin n_bad++; $display("FAIL rst_req: got %b want 0", trap_req); end
        n_vec++; if (trap_vector !== 9'd0) begin n_bad++; $display("FAIL rst_vec: got %o want 0", trap_vector); end
        n_vec++; if (trap_ipl !== 3'd0) begin n_bad++; $display("FAIL rst_ipl: got %0d want 0", trap_ipl); end
        n_vec++; if (busy !== 1'b0 || timeout_err !== 1'b0) begin n_bad++; $display("FAIL rst_busy_terr: got %b%b want 00", busy, timeout_err); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        result = 1'b1; winner = 8'h20; cpu_int_ok = 1'b1;
        tick();
        n_vec++; if (int_grant !== 8'h20) begin n_bad++; $display("FAIL basic_grant: got %h want 20", int_grant); end
        n_vec++; if (busy !== 1'b1 || trap_ipl !== 3'd5) begin n_bad++; $display("FAIL basic_busy_ipl: got %b/%0d want 1/5", busy, trap_ipl); end
        winner = 8'h80;
        tick();
        n_vec++; if (int_grant !== 8'h20) begin n_bad++; $display("FAIL latch_grant: got %h want 20", int_grant); end
        result = 1'b0; winner = 8'h00; cpu_int_ok = 1'b0;
        int_ack = 1'b1; int_vector = 9'o060;
        tick();
        int_ack = 1'b0; int_vector = 9'o777;
        n_vec++; if (int_grant !== 8'h00 || trap_req !== 1'b1) begin n_bad++; $display("FAIL basic_present: got grant %h req %b want 00 1", int_grant, trap_req); end
        n_vec++; if (trap_vector !== 9'o060 || trap_ipl !== 3'd5) begin n_bad++; $display("FAIL basic_vec: got %o/%0d want 060/5", trap_vector, trap_ipl); end
        tick();
        n_vec++; if (trap_req !== 1'b1 || trap_vector !== 9'o060) begin n_bad++; $display("FAIL basic_hold: got %b/%o want 1/060", trap_req, trap_vector); end
        trap_ack = 1'b1;
        tick();
        trap_ack = 1'b0;
        n_vec++; if (trap_req !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL basic_done: got req %b busy %b want 0 0", trap_req, busy); end
        n_vec++; if (trap_vector !== 9'o060 || trap_ipl !== 3'd5) begin n_bad++; $display("FAIL basic_keep: got %o/%0d want 060/5", trap_vector, trap_ipl); end
    endtask

    task automatic test_alignment();
        result = 1'b1; winner = 8'h08; cpu_int_ok = 1'b1;
        tick();
        idle_inputs();
        int_ack = 1'b1; int_vector = 9'o377;
        tick();
        int_ack = 1'b0;
        n_vec++; if (trap_vector !== 9'o374 || trap_ipl !== 3'd3) begin n_bad++; $display("FAIL align_vec: got %o/%0d want 374/3", trap_vector, trap_ipl); end
        trap_ack = 1'b1;
        tick();
        trap_ack = 1'b0;
    endtask

    task automatic test_gating();
        result = 1'b1; winner = 8'h10; cpu_int_ok = 1'b0;
        tick(); tick();
        n_vec++; if (int_grant !== 8'h00 || busy !== 1'b0) begin n_bad++; $display("FAIL gate_cpu_ok: got %h/%b want 00/0", int_grant, busy); end
        winner = 8'h00; cpu_int_ok = 1'b1;
        tick();
        n_vec++; if (int_grant !== 8'h00 || busy !== 1'b0) begin n_bad++; $display("FAIL gate_winner0: got %h/%b want 00/0", int_grant, busy); end
        result = 1'b0; winner = 8'h10;
        tick();
        n_vec++; if (int_grant !== 8'h00 || busy !== 1'b0) begin n_bad++; $display("FAIL gate_result0: got %h/%b want 00/0", int_grant, busy); end
        idle_inputs();
        int_ack = 1'b1; trap_ack = 1'b1; int_vector = 9'o123;
        tick();
        idle_inputs();
        n_vec++; if (trap_req !== 1'b0 || int_grant !== 8'h00 || busy !== 1'b0) begin n_bad++; $display("FAIL stray_ctrl: got req %b grant %h busy %b want 0 00 0", trap_req, int_grant, busy); end
        n_vec++; if (trap_vector !== 9'o374 || trap_ipl !== 3'd3) begin n_bad++; $display("FAIL stray_vec: got %o/%0d want 374/3", trap_vector, trap_ipl); end
    endtask

    task automatic test_timeout();
        result = 1'b1; winner = 8'h04; cpu_int_ok = 1'b1;
        tick();
        idle_inputs();
`ifdef INT_TIMEOUT_EN
        for (int i = 1; i <= 15; i++) begin
            tick();
            n_vec++; if (int_grant !== 8'h04 || timeout_err !== 1'b0) begin n_bad++; $display("FAIL tmo_wait%0d: got %h/%b want 04/0", i, int_grant, timeout_err); end
        end
        tick();
        n_vec++; if (int_grant !== 8'h00 || timeout_err !== 1'b1) begin n_bad++; $display("FAIL tmo_release: got %h/%b want 00/1", int_grant, timeout_err); end
        n_vec++; if (trap_req !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL tmo_idle: got req %b busy %b want 0 0", trap_req, busy); end
        tick();
        n_vec++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL tmo_pulse: got %b want 0", timeout_err); end
        result = 1'b1; winner = 8'h04; cpu_int_ok = 1'b1;
        tick();
        idle_inputs();
        for (int i = 1; i <= 15; i++) tick();
        int_ack = 1'b1; int_vector = 9'o200;
        tick();
        int_ack = 1'b0;
        n_vec++; if (trap_req !== 1'b1 || timeout_err !== 1'b0) begin n_bad++; $display("FAIL tmo_ack_wins: got req %b terr %b want 1 0", trap_req, timeout_err); end
        n_vec++; if (trap_vector !== 9'o200 || trap_ipl !== 3'd2) begin n_bad++; $display("FAIL tmo_ack_vec: got %o/%0d want 200/2", trap_vector, trap_ipl); end
`else
        for (int i = 1; i <= 40; i++) begin
            tick();
            n_vec++; if (int_grant !== 8'h04 || timeout_err !== 1'b0) begin n_bad++; $display("FAIL nto_hold%0d: got %h/%b want 04/0", i, int_grant, timeout_err); end
        end
        int_ack = 1'b1; int_vector = 9'o200;
        tick();
        int_ack = 1'b0;
        n_vec++; if (trap_req !== 1'b1 || trap_vector !== 9'o200) begin n_bad++; $display("FAIL nto_ack: got %b/%o want 1/200", trap_req, trap_vector); end
`endif
        trap_ack = 1'b1;
        tick();
        trap_ack = 1'b0;
    endtask

    task automatic test_reset_mid();
        result = 1'b1; winner = 8'h40; cpu_int_ok = 1'b1;
        tick();
        idle_inputs();
        int_ack = 1'b1; int_vector = 9'o100;
        tick();
        int_ack = 1'b0;
        n_vec++; if (trap_req !== 1'b1 || trap_ipl !== 3'd6) begin n_bad++; $display("FAIL rmid_pre: got %b/%0d want 1/6", trap_req, trap_ipl); end
        #2 reset = 1'b1;
        #1;
        n_vec++; if (trap_req !== 1'b0 || int_grant !== 8'h00 || busy !== 1'b0) begin n_bad++; $display("FAIL rmid_ctrl: got req %b grant %h busy %b want 0 00 0", trap_req, int_grant, busy); end
        n_vec++; if (trap_vector !== 9'd0 || trap_ipl !== 3'd0) begin n_bad++; $display("FAIL rmid_vec: got %o/%0d want 0/0", trap_vector, trap_ipl); end
        #2 reset = 1'b0;
        result = 1'b1; winner = 8'h02; cpu_int_ok = 1'b1;
        tick();
        idle_inputs();
        n_vec++; if (int_grant !== 8'h02 || trap_ipl !== 3'd1) begin n_bad++; $display("FAIL rmid_regrant: got %h/%0d want 02/1", int_grant, trap_ipl); end
        int_ack = 1'b1; int_vector = 9'o004;
        tick();
        int_ack = 1'b0; trap_ack = 1'b1;
        tick();
        trap_ack = 1'b0;
    endtask

    task automatic test_back_to_back();
        result = 1'b1; winner = 8'h02; cpu_int_ok = 1'b1;
        tick();
        n_vec++; if (int_grant !== 8'h02) begin n_bad++; $display("FAIL b2b_grant1: got %h want 02", int_grant); end
        int_ack = 1'b1; int_vector = 9'o010;
        tick();
        int_ack = 1'b0;
        n_vec++; if (trap_req !== 1'b1 || trap_vector !== 9'o010) begin n_bad++; $display("FAIL b2b_present: got %b/%o want 1/010", trap_req, trap_vector); end
        trap_ack = 1'b1;
        tick();
        trap_ack = 1'b0;
        n_vec++; if (trap_req !== 1'b0 || int_grant !== 8'h00 || busy !== 1'b0) begin n_bad++; $display("FAIL b2b_via_idle: got req %b grant %h busy %b want 0 00 0", trap_req, int_grant, busy); end
        tick();
        n_vec++; if (int_grant !== 8'h02 || busy !== 1'b1 || trap_ipl !== 3'd1) begin n_bad++; $display("FAIL b2b_grant2: got %h/%b/%0d want 02/1/1", int_grant, busy, trap_ipl); end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_alignment();
        test_gating();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/bus_int_ack.md
# bus_int_ack

Interrupt acknowledge sequencer that sits directly downstream of the IPL priority comparator. It takes the comparator's "pending above IPL" flag and one-hot winner and, at a CPU-signalled instruction boundary, issues a bus grant to the winning level. It then captures the device's interrupt vector and presents a trap request (vector plus new IPL) to the CPU trap logic with a request/acknowledge handshake.

## Interface

- TIMEOUT, 16: cycles a grant may stay outstanding without a device reply; used only with INT_TIMEOUT_EN.
- TCW, 5: timeout counter width; must satisfy 2^TCW > TIMEOUT.

Ports:
- clk  input  1  single clock; all state is on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- result  input  1  an interrupt is pending above the current IPL.
- winner  input  8  one-hot highest pending level; 0 means none.
- cpu_int_ok  input  1  CPU is at an instruction boundary and accepts interrupts.
- int_ack  input  1  device reply strobe, valid only while the grant is asserted.
- int_vector  input  9  device vector (0–0777).
- trap_ack  input  1  CPU has consumed the trap request.
- int_grant  output  8  registered one-hot bus grant to the winning level.
- trap_req  output  1  vector is valid and the trap is requested.
- trap_vector  output  9  captured vector with bits [1:0] forced to 0.
- trap_ipl  output  3  binary level of the granted request.
- busy  output  1  high in any state other than IDLE.
- timeout_err  output  1  one-cycle pulse on a grant timeout (passive release).

## Operation

- Reset values: state IDLE, int_grant=0, trap_req=0, trap_vector=0, trap_ipl=0, busy=0, timeout_err=0, timeout counter=0.
- States: IDLE, GRANT, PRESENT.
- IDLE:
  - If result && cpu_int_ok && winner!=0, latch winner into int_grant and the encoded level (bit index 7..1) into trap_ipl, clear the counter, and go to GRANT.
  - If result=1 but winner=0, stay in IDLE.
- GRANT:
  - int_grant is held at its latched value; later changes on winner, result or cpu_int_ok are ignored.
  - On int_ack, set trap_vector = {int_vector[8:2],2'b00}, clear int_grant, go to PRESENT.
  - Otherwise the counter increments (INT_TIMEOUT_EN only).
- PRESENT:
  - trap_req=1; trap_vector and trap_ipl are held stable.
  - On trap_ack, clear trap_req and go to IDLE.
  - trap_vector and trap_ipl keep their values until the next capture.
- Ignored inputs:
  - int_ack in IDLE or PRESENT has no effect.
  - trap_ack outside PRESENT has no effect.
- Simultaneous events:
  - int_ack in the same cycle the counter reaches TIMEOUT: the ack wins and no timeout_err is raised.
  - trap_ack plus a new pending request in the same cycle: go to IDLE first; no direct PRESENT→GRANT transition.
- Reset asserted mid-operation (any state) forces all reset values immediately and asynchronously. A grant outstanding at that moment is dropped.

## Timing

- All outputs are registered.
- Request → grant:
  - IDLE conditions true at edge N → int_grant valid after edge N, busy=1 the same cycle.
  - Minimum gap from request to grant is 1 cycle.
- int_ack sampled at edge M → after M: int_grant=0, trap_req=1, trap_vector valid.
- trap_ack sampled at edge K → after K: trap_req=0, state IDLE. The earliest next grant appears after edge K+1.
- Minimum full sequence is 3 edges: grant, ack, trap_ack.
- Throughput is at most one interrupt per 3 cycles.
- Timeout (INT_TIMEOUT_EN):
  - The counter counts GRANT cycles without int_ack.
  - When it reaches TIMEOUT, at the next edge: int_grant=0, state IDLE, timeout_err=1 for exactly one cycle, no trap_req.

## Configuration

- INT_TIMEOUT_EN defined: timeout counter and passive release are implemented as described.
- INT_TIMEOUT_EN undefined:
  - No counter is built; GRANT waits indefinitely for int_ack.
  - timeout_err is tied to 0.
  - TIMEOUT and TCW are unused.

## Test plan

- Basic sequence: reset; result=1, winner=8'h20, cpu_int_ok=1 → int_grant=8'h20 next cycle. Then int_ack with int_vector=9'o060 → trap_req=1, trap_vector=9'o060, trap_ipl=5. Then trap_ack → trap_req=0, busy=0.
- Vector alignment and latching:
  - int_vector=9'o377 → trap_vector=9'o374.
  - Changing winner to 8'h80 during GRANT leaves int_grant=8'h20.
- Gating:
  - result=1 with cpu_int_ok=0 → int_grant stays 0.
  - winner=0 with result=1 → stays IDLE.
  - Stray int_ack or trap_ack while in IDLE → no output change.
- Timeout (INT_TIMEOUT_EN, TIMEOUT=16):
  - Grant with no ack → after 16 GRANT cycles, int_grant=0 and timeout_err pulses for 1 cycle.
  - int_ack on the 16th cycle → trap_req=1, no timeout_err.
- Reset mid-PRESENT: assert reset between edges → trap_req, int_grant, trap_vector and trap_ipl go to 0 immediately. After release, a new request is granted normally.
- Back-to-back: winner held at 8'h02 through trap_ack → second grant appears 2 edges after trap_ack, trap_ipl=1.
